// File: rtl/operand_fetch.sv
// Issue stage ahead of execute: drives regfile read ports, bypasses EX/MEM/WB results,
// stalls on load-use hazards and holds the ID->EX register behind a valid/ready handshake.
module operand_fetch #(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XLEN-1:0]  in_pc,
  input  logic [4:0]       in_rs1,
  input  logic [4:0]       in_rs2,
  input  logic             in_use_rs1,
  input  logic             in_use_rs2,
  input  logic [4:0]       in_rd,
  input  logic             in_rd_we,
  output logic [4:0]       rf_ra1,
  output logic [4:0]       rf_ra2,
  input  logic [XLEN-1:0]  rf_rd1,
  input  logic [XLEN-1:0]  rf_rd2,
  input  logic             ex_valid,
  input  logic [4:0]       ex_rd,
  input  logic             ex_we,
  input  logic             ex_is_load,
  input  logic [XLEN-1:0]  ex_data,
  input  logic             mem_valid,
  input  logic [4:0]       mem_rd,
  input  logic             mem_we,
  input  logic             mem_dvalid,
  input  logic [XLEN-1:0]  mem_data,
  input  logic             wb_valid,
  input  logic [4:0]       wb_rd,
  input  logic             wb_we,
  input  logic [XLEN-1:0]  wb_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_pc,
  output logic [XLEN-1:0]  out_op1,
  output logic [XLEN-1:0]  out_op2,
  output logic [4:0]       out_rd,
  output logic             out_rd_we,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic            ex_m1, mem_m1, wb_m1;
  logic            ex_m2, mem_m2, wb_m2;
  logic            haz1, haz2, hazard;
  logic            accept;
  logic [XLEN-1:0] op1, op2;

  // Register x0 is hard-wired, so it never matches a producer.
  function automatic logic producer_match(input logic v, input logic we,
                                          input logic [4:0] prd, input logic [4:0] src);
    return v && we && (prd == src) && (src != 5'd0);
  endfunction

  assign rf_ra1 = in_rs1;
  assign rf_ra2 = in_rs2;

  assign ex_m1  = producer_match(ex_valid,  ex_we,  ex_rd,  in_rs1);
  assign mem_m1 = producer_match(mem_valid, mem_we, mem_rd, in_rs1);
  assign wb_m1  = producer_match(wb_valid,  wb_we,  wb_rd,  in_rs1);
  assign ex_m2  = producer_match(ex_valid,  ex_we,  ex_rd,  in_rs2);
  assign mem_m2 = producer_match(mem_valid, mem_we, mem_rd, in_rs2);
  assign wb_m2  = producer_match(wb_valid,  wb_we,  wb_rd,  in_rs2);

  // Operand select: youngest producer wins; the regfile does not forward its own write.
  always_comb begin
    op1 = rf_rd1;
    if (ex_m1)                op1 = ex_data;
    else if (mem_m1)          op1 = mem_data;
    else if (wb_m1)           op1 = wb_data;
    else if (in_rs1 == 5'd0)  op1 = '0;

    op2 = rf_rd2;
    if (ex_m2)                op2 = ex_data;
    else if (mem_m2)          op2 = mem_data;
    else if (wb_m2)           op2 = wb_data;
    else if (in_rs2 == 5'd0)  op2 = '0;
  end

  // Any not-yet-available producer result stalls, regardless of other matches.
  assign haz1   = in_use_rs1 && ((ex_m1 && ex_is_load) || (mem_m1 && !mem_dvalid));
  assign haz2   = in_use_rs2 && ((ex_m2 && ex_is_load) || (mem_m2 && !mem_dvalid));
  assign hazard = in_valid && (haz1 || haz2);

  assign in_ready = !hazard && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_pc    <= '0;
      out_op1   <= '0;
      out_op2   <= '0;
      out_rd    <= 5'd0;
      out_rd_we <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_pc    <= in_pc;
      out_op1   <= op1;
      out_op2   <= op2;
      out_rd    <= in_rd;
      out_rd_we <= in_rd_we;
    end else if (out_ready && out_valid) begin
      out_valid <= 1'b0;
    end
  end

  // Saturating stall performance counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (hazard && !flush && (stall_cnt != CNT_MAX)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_operand_fetch.sv
// Self-checking bench for operand_fetch: directed scenarios plus randomized traffic
// compared against a producer-list reference model.
module tb_operand_fetch;

  localparam int unsigned XLEN  = 64;
  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] CMAX = {CNT_W{1'b1}};

  logic clk = 1'b0;
  logic reset, flush, in_valid, in_ready, in_use_rs1, in_use_rs2, in_rd_we;
  logic [XLEN-1:0] in_pc, rf_rd1, rf_rd2, ex_data, mem_data, wb_data;
  logic [4:0] in_rs1, in_rs2, in_rd, rf_ra1, rf_ra2, ex_rd, mem_rd, wb_rd, out_rd;
  logic ex_valid, ex_we, ex_is_load, mem_valid, mem_we, mem_dvalid, wb_valid, wb_we;
  logic out_valid, out_ready, out_rd_we;
  logic [XLEN-1:0] out_pc, out_op1, out_op2;
  logic [CNT_W-1:0] stall_cnt;

  logic [XLEN-1:0] regs [32];
  int errors = 0;
  int checks = 0;

  // Reference model state
  logic             m_valid, m_rd_we;
  logic [XLEN-1:0]  m_pc, m_op1, m_op2;
  logic [4:0]       m_rd;
  logic [CNT_W-1:0] m_cnt;

  always #5 clk = ~clk;

  assign rf_rd1 = regs[rf_ra1];
  assign rf_rd2 = regs[rf_ra2];

  operand_fetch #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_use_rs1(in_use_rs1), .in_use_rs2(in_use_rs2),
    .in_rd(in_rd), .in_rd_we(in_rd_we),
    .rf_ra1(rf_ra1), .rf_ra2(rf_ra2), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
    .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_we(ex_we), .ex_is_load(ex_is_load), .ex_data(ex_data),
    .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_we(mem_we), .mem_dvalid(mem_dvalid),
    .mem_data(mem_data),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_we(wb_we), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_op1(out_op1), .out_op2(out_op2), .out_rd(out_rd), .out_rd_we(out_rd_we),
    .stall_cnt(stall_cnt)
  );

  // Walk the producer list youngest-first: first writer supplies the value,
  // any writer whose data is not ready yet raises a hazard for a used source.
  task automatic resolve(input logic [4:0] s, input logic use_s,
                         output logic [XLEN-1:0] val, output logic haz);
    logic            pv [3];
    logic [4:0]      prd [3];
    logic [XLEN-1:0] pd [3];
    logic            pnr [3];
    logic            found;
    pv[0] = ex_valid && ex_we;   prd[0] = ex_rd;  pd[0] = ex_data;  pnr[0] = ex_is_load;
    pv[1] = mem_valid && mem_we; prd[1] = mem_rd; pd[1] = mem_data; pnr[1] = !mem_dvalid;
    pv[2] = wb_valid && wb_we;   prd[2] = wb_rd;  pd[2] = wb_data;  pnr[2] = 1'b0;
    val = (s == 5'd0) ? '0 : regs[s];
    haz = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (s != 5'd0 && pv[i] && prd[i] == s) begin
        if (!found) val = pd[i];
        found = 1'b1;
        if (use_s && pnr[i]) haz = 1'b1;
      end
    end
  endtask

  task automatic model_expect(output logic rdy, output logic hz,
                              output logic [XLEN-1:0] v1, output logic [XLEN-1:0] v2);
    logic h1, h2;
    resolve(in_rs1, in_use_rs1, v1, h1);
    resolve(in_rs2, in_use_rs2, v2, h2);
    hz  = in_valid && (h1 || h2);
    rdy = !hz && (!m_valid || out_ready);
  endtask

  task automatic model_clear();
    m_valid = 0; m_rd_we = 0; m_pc = '0; m_op1 = '0; m_op2 = '0; m_rd = '0; m_cnt = '0;
  endtask

  // One clock: update the model from the current inputs, then land #1 after the edge.
  task automatic advance();
    logic rdy, hz;
    logic [XLEN-1:0] v1, v2;
    model_expect(rdy, hz, v1, v2);
    @(posedge clk);
    if (flush) m_valid = 0;
    else if (in_valid && rdy) begin
      m_valid = 1; m_pc = in_pc; m_op1 = v1; m_op2 = v2; m_rd = in_rd; m_rd_we = in_rd_we;
    end else if (out_ready && m_valid) m_valid = 0;
    if (hz && !flush && m_cnt != CMAX) m_cnt = m_cnt + CNT_W'(1);
    #1;
  endtask

  task automatic idle();
    flush = 0; in_valid = 0; in_pc = '0; in_rs1 = 0; in_rs2 = 0; in_use_rs1 = 0; in_use_rs2 = 0;
    in_rd = 0; in_rd_we = 0; out_ready = 1;
    ex_valid = 0; ex_rd = 0; ex_we = 0; ex_is_load = 0; ex_data = '0;
    mem_valid = 0; mem_rd = 0; mem_we = 0; mem_dvalid = 0; mem_data = '0;
    wb_valid = 0; wb_rd = 0; wb_we = 0; wb_data = '0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1;
    model_clear();
    @(posedge clk);
    #1;
    reset = 0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 32; i++) regs[i] = {$urandom, $urandom};
    reset = 0;
    do_reset();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    checks++; if (out_pc !== '0 || out_op1 !== '0 || out_op2 !== '0) begin errors++; $display("FAIL reset_data: pc %h op1 %h op2 %h want 0", out_pc, out_op1, out_op2); end
    checks++; if (out_rd !== 5'd0 || out_rd_we !== 1'b0) begin errors++; $display("FAIL reset_rd: rd %0d we %b want 0", out_rd, out_rd_we); end
    checks++; if (stall_cnt !== '0) begin errors++; $display("FAIL reset_cnt: got %0d want 0", stall_cnt); end
  endtask

  task automatic test_rf_read();
    regs[5] = 64'h11;
    in_valid = 1; in_rs1 = 5; in_use_rs1 = 1; in_pc = 64'h40; in_rd = 9; in_rd_we = 1;
    #1;
    checks++; if (rf_ra1 !== 5'd5) begin errors++; $display("FAIL rf_ra1: got %0d want 5", rf_ra1); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rf_ready: got %b want 1", in_ready); end
    advance();
    in_valid = 0;
    checks++; if (out_valid !== 1'b1 || out_op1 !== 64'h11) begin errors++; $display("FAIL rf_read: valid %b op1 %h want 1 11", out_valid, out_op1); end
    checks++; if (out_pc !== 64'h40 || out_rd !== 5'd9 || out_rd_we !== 1'b1) begin errors++; $display("FAIL rf_meta: pc %h rd %0d we %b want 40 9 1", out_pc, out_rd, out_rd_we); end
    advance();
  endtask

  task automatic test_back_to_back();
    regs[5] = 64'h11;
    in_valid = 1; in_rs1 = 5; in_use_rs1 = 1; out_ready = 1;
    ex_valid = 1; ex_rd = 5; ex_we = 1; ex_data = 64'hAA;
    mem_valid = 1; mem_rd = 5; mem_we = 1; mem_dvalid = 1; mem_data = 64'hBB;
    wb_valid = 1; wb_rd = 5; wb_we = 1; wb_data = 64'hCC;
    advance();
    checks++; if (out_op1 !== 64'hAA) begin errors++; $display("FAIL byp_ex: got %h want aa", out_op1); end
    ex_valid = 0;
    advance();
    checks++; if (out_op1 !== 64'hBB || out_valid !== 1'b1) begin errors++; $display("FAIL byp_mem: got %h v %b want bb 1", out_op1, out_valid); end
    mem_valid = 0;
    advance();
    checks++; if (out_op1 !== 64'hCC || out_valid !== 1'b1) begin errors++; $display("FAIL byp_wb: got %h v %b want cc 1", out_op1, out_valid); end
    idle();
    advance();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain: got %b want 0", out_valid); end
  endtask

  task automatic test_load_use();
    do_reset();
    in_valid = 1; in_rs2 = 7; in_use_rs2 = 1;
    ex_valid = 1; ex_rd = 7; ex_we = 1; ex_is_load = 1; ex_data = 64'h99;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL lu_stall: ready %b want 0", in_ready); end
    advance();
    checks++; if (stall_cnt !== 4'd1 || out_valid !== 1'b0) begin errors++; $display("FAIL lu_cnt: cnt %0d v %b want 1 0", stall_cnt, out_valid); end
    ex_valid = 0; ex_is_load = 0;
    mem_valid = 1; mem_rd = 7; mem_we = 1; mem_dvalid = 1; mem_data = 64'h55;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL lu_release: ready %b want 1", in_ready); end
    advance();
    checks++; if (out_valid !== 1'b1 || out_op2 !== 64'h55 || stall_cnt !== 4'd1) begin errors++; $display("FAIL lu_op2: v %b op2 %h cnt %0d want 1 55 1", out_valid, out_op2, stall_cnt); end
    mem_dvalid = 0;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL mem_pending: ready %b want 0", in_ready); end
    idle();
    advance();
  endtask

  task automatic test_zero_and_unused();
    do_reset();
    in_valid = 1; in_rs1 = 0; in_use_rs1 = 1;
    ex_valid = 1; ex_rd = 0; ex_we = 1; ex_is_load = 1; ex_data = 64'hFF;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL x0_ready: got %b want 1", in_ready); end
    advance();
    checks++; if (out_op1 !== '0 || stall_cnt !== '0) begin errors++; $display("FAIL x0_op1: op1 %h cnt %0d want 0 0", out_op1, stall_cnt); end
    in_rs1 = 3; in_use_rs1 = 0; ex_rd = 3; ex_data = 64'h33;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL unused_ready: got %b want 1", in_ready); end
    advance();
    checks++; if (stall_cnt !== '0 || out_op1 !== 64'h33) begin errors++; $display("FAIL unused_op: cnt %0d op1 %h want 0 33", stall_cnt, out_op1); end
    idle();
    advance();
  endtask

  task automatic test_backpressure_flush();
    do_reset();
    in_valid = 1; in_pc = 64'h100; in_rd = 4; in_rd_we = 1;
    advance();
    out_ready = 0; in_pc = 64'h200; in_rd = 6;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready: got %b want 0", in_ready); end
    advance();
    checks++; if (out_valid !== 1'b1 || out_pc !== 64'h100 || out_rd !== 5'd4) begin errors++; $display("FAIL bp_hold: v %b pc %h rd %0d want 1 100 4", out_valid, out_pc, out_rd); end
    flush = 1; out_ready = 1;
    advance();
    checks++; if (out_valid !== 1'b0 || out_pc !== 64'h100) begin errors++; $display("FAIL flush: v %b pc %h want 0 100", out_valid, out_pc); end
    idle();
    advance();
    checks++; if (out_valid !== 1'b0 || out_pc !== 64'h100) begin errors++; $display("FAIL flush_drop: v %b pc %h want 0 100", out_valid, out_pc); end
  endtask

  task automatic test_async_reset();
    do_reset();
    in_valid = 1; out_ready = 0; in_pc = 64'h300;
    advance();
    in_pc = 64'h304; in_rs1 = 2; in_use_rs1 = 1;
    ex_valid = 1; ex_rd = 2; ex_we = 1; ex_is_load = 1;
    advance();
    advance();
    checks++; if (stall_cnt !== 4'd2 || out_valid !== 1'b1) begin errors++; $display("FAIL pre_rst: cnt %0d v %b want 2 1", stall_cnt, out_valid); end
    #1 reset = 1;
    #1;
    checks++; if (out_valid !== 1'b0 || stall_cnt !== '0 || out_pc !== '0) begin errors++; $display("FAIL async_rst: v %b cnt %0d pc %h want 0 0 0", out_valid, stall_cnt, out_pc); end
    model_clear();
    reset = 0;
    idle();
    advance();
  endtask

  task automatic test_saturation();
    do_reset();
    in_valid = 1; in_rs2 = 8; in_use_rs2 = 1;
    mem_valid = 1; mem_rd = 8; mem_we = 1; mem_dvalid = 0;
    for (int i = 0; i < 20; i++) advance();
    checks++; if (stall_cnt !== CMAX) begin errors++; $display("FAIL sat: got %0d want %0d", stall_cnt, CMAX); end
    flush = 1;
    advance();
    checks++; if (stall_cnt !== CMAX) begin errors++; $display("FAIL sat_hold: got %0d want %0d", stall_cnt, CMAX); end
    idle();
    advance();
  endtask

  task automatic test_random();
    logic rdy, hz;
    logic [XLEN-1:0] v1, v2;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      in_valid = ($urandom_range(0, 3) != 0); flush = ($urandom_range(0, 15) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      in_pc = {$urandom, $urandom}; in_rs1 = 5'($urandom_range(0, 7)); in_rs2 = 5'($urandom_range(0, 7));
      in_use_rs1 = 1'($urandom); in_use_rs2 = 1'($urandom); in_rd = 5'($urandom); in_rd_we = 1'($urandom);
      ex_valid = 1'($urandom); ex_rd = 5'($urandom_range(0, 7)); ex_we = 1'($urandom);
      ex_is_load = ($urandom_range(0, 3) == 0); ex_data = {$urandom, $urandom};
      mem_valid = 1'($urandom); mem_rd = 5'($urandom_range(0, 7)); mem_we = 1'($urandom);
      mem_dvalid = ($urandom_range(0, 3) != 0); mem_data = {$urandom, $urandom};
      wb_valid = 1'($urandom); wb_rd = 5'($urandom_range(0, 7)); wb_we = 1'($urandom);
      wb_data = {$urandom, $urandom};
      #1;
      model_expect(rdy, hz, v1, v2);
      checks++; if (in_ready !== rdy || rf_ra1 !== in_rs1 || rf_ra2 !== in_rs2) begin errors++; $display("FAIL rnd_comb[%0d]: ready %b ra %0d/%0d want %b %0d/%0d", n, in_ready, rf_ra1, rf_ra2, rdy, in_rs1, in_rs2); end
      advance();
      checks++;
      if (out_valid !== m_valid || out_pc !== m_pc || out_op1 !== m_op1 || out_op2 !== m_op2 ||
          out_rd !== m_rd || out_rd_we !== m_rd_we || stall_cnt !== m_cnt) begin
        errors++;
        $display("FAIL rnd_out[%0d]: v %b pc %h op %h/%h rd %0d/%b cnt %0d want v %b pc %h op %h/%h rd %0d/%b cnt %0d",
                 n, out_valid, out_pc, out_op1, out_op2, out_rd, out_rd_we, stall_cnt,
                 m_valid, m_pc, m_op1, m_op2, m_rd, m_rd_we, m_cnt);
      end
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_rf_read();
    test_back_to_back();
    test_load_use();
    test_zero_and_unused();
    test_backpressure_flush();
    test_async_reset();
    test_saturation();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
